// File: rtl/clk_step_controller.sv
// Slow-domain sequencer for the SAD pipeline. It emits one-Clk-cycle Tick enables in three modes:
// RUN (divided), STEP (pushbutton) or HALT. The divisor is runtime-loadable with an ack/err handshake.
module clk_step_controller #(
  parameter int CNT_W       = 25,
  parameter int DEF_DIV     = 50,
  parameter int SYNC_STAGES = 2,
  parameter int TC_W        = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [1:0]       Mode,
  input  logic             StepBtn,
  input  logic [CNT_W-1:0] DivIn,
  input  logic             DivLoad,
  output logic             DivAck,
  output logic             DivErr,
  output logic             Tick,
  output logic             Phase,
  output logic             Busy,
  output logic [TC_W-1:0]  TickCount
);

  // A synchronizer shorter than two flops cannot settle metastability, so clamp it.
  localparam int SyncN = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {
    HALT = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10
  } stateT;

  stateT            state, nextState;
  logic [CNT_W-1:0] div, divNext;
  logic [CNT_W-1:0] divCnt, divCntNext;
  logic [SyncN-1:0] syncReg;
  logic             syncPrev;
  logic             stepEdge;
  logic             runCount;
  logic             terminal;
  logic             loadOk;
  logic             tickNext;
  logic             divAckNext;
  logic             divErrNext;

  // NOTE: every signal driven here gets a default first, so no branch can leave one unassigned (no latches).
  always_comb begin
    nextState  = HALT;
    divNext    = div;
    divCntNext = '0;
    tickNext   = 1'b0;
    divAckNext = 1'b0;
    divErrNext = 1'b0;
    runCount   = 1'b0;
    terminal   = 1'b0;
    loadOk     = 1'b0;

    case (Mode)
      2'b01:   nextState = RUN;
      2'b10:   nextState = STEP;
      default: nextState = HALT;
    endcase

    // Counting only continues while RUN persists; the exit cycle clears DivCnt with no partial Tick.
    runCount = (state == RUN) && (nextState == RUN);
    terminal = (divCnt == div - CNT_W'(1));
    loadOk   = DivLoad && (DivIn != '0);

    if (runCount) begin
      if (terminal) begin
        tickNext = 1'b1;
      end else begin
        divCntNext = divCnt + CNT_W'(1);
      end
    end

    // Edges seen outside STEP are simply dropped.
    if ((state == STEP) && stepEdge) begin
      tickNext = 1'b1;
    end

    if (DivLoad) begin
      if (loadOk) begin
        divNext    = DivIn;
        divCntNext = '0;
        divAckNext = 1'b1;
        // An accepted load restarts the period, overriding a coincident terminal count.
        if (runCount) begin
          tickNext = 1'b0;
        end
      end else begin
        divErrNext = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state     <= HALT;
      div       <= CNT_W'(DEF_DIV);
      divCnt    <= '0;
      syncReg   <= '0;
      syncPrev  <= 1'b0;
      stepEdge  <= 1'b0;
      Tick      <= 1'b0;
      Phase     <= 1'b0;
      Busy      <= 1'b0;
      DivAck    <= 1'b0;
      DivErr    <= 1'b0;
      TickCount <= '0;
    end else begin
      state     <= nextState;
      div       <= divNext;
      divCnt    <= divCntNext;
      syncReg   <= {syncReg[SyncN-2:0], StepBtn};
      syncPrev  <= syncReg[SyncN-1];
      stepEdge  <= syncReg[SyncN-1] & ~syncPrev;
      Tick      <= tickNext;
      Phase     <= Phase ^ tickNext;
      Busy      <= (nextState == RUN);
      DivAck    <= divAckNext;
      DivErr    <= divErrNext;
      TickCount <= TickCount + TC_W'(tickNext);
    end
  end

endmodule

// File: tb/tb_clk_step_controller.sv
// Bench for clk_step_controller: table-driven RUN vectors plus hand sequences for loads, STEP and reset.
// A scoreboard queue holds the expected Tick cycles, which the negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_clk_step_controller;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_ALT  = 2'b11;
  localparam int         NVEC      = 8;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [1:0]  Mode;
  logic        StepBtn;
  logic [24:0] DivIn;
  logic        DivLoad;
  logic        DivAck;
  logic        DivErr;
  logic        Tick;
  logic        Phase;
  logic        Busy;
  logic [15:0] TickCount;

  clk_step_controller dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Mode      (Mode),
    .StepBtn   (StepBtn),
    .DivIn     (DivIn),
    .DivLoad   (DivLoad),
    .DivAck    (DivAck),
    .DivErr    (DivErr),
    .Tick      (Tick),
    .Phase     (Phase),
    .Busy      (Busy),
    .TickCount (TickCount)
  );

  always #10 Clk = ~Clk;

  typedef struct {
    int          cyc;
    logic        phase;
    logic [15:0] cnt;
  } expTickT;

  typedef struct {
    logic        load;
    logic [24:0] divIn;
    logic        expAck;
    logic        expErr;
    int          period;
    int          nTicks;
    logic [1:0]  haltMode;
  } vecT;

  expTickT     sb[$];
  expTickT     monE;
  vecT         vecs[NVEC];
  int          cyc = 0;
  int          nApplied = 0;
  int          nMiss = 0;
  logic        monEn = 1'b0;
  logic        modelPhase = 1'b0;
  logic [15:0] modelCnt = 16'd0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Outputs are sampled on the falling edge; after posedge n the cycle counter reads n.
  always @(negedge Clk) begin
    if (monEn) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        check("tick_missed", 32'(cyc), 32'(sb[0].cyc));
        void'(sb.pop_front());
      end
      if (Tick) begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
          monE = sb.pop_front();
          check("tick_phase", 32'(Phase), 32'(monE.phase));
          check("tick_count", 32'(TickCount), 32'(monE.cnt));
        end else begin
          check("tick_unexpected", 32'(Tick), 32'd0);
        end
      end
    end
  end

  task automatic tick_clk(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic push_ticks(input int first, input int period, input int n, output int last);
    expTickT e;
    last = first;
    for (int k = 0; k < n; k++) begin
      modelPhase = ~modelPhase;
      modelCnt   = modelCnt + 16'd1;
      e.cyc      = first + k * period;
      e.phase    = modelPhase;
      e.cnt      = modelCnt;
      sb.push_back(e);
      last = e.cyc;
    end
  endtask

  task automatic do_load(input logic [24:0] v, input logic expAck, input logic expErr);
    DivIn   = v;
    DivLoad = 1'b1;
    tick_clk(1);
    DivLoad = 1'b0;
    check("div_ack", 32'(DivAck), 32'(expAck));
    check("div_err", 32'(DivErr), 32'(expErr));
    tick_clk(1);
    check("ack_pulse_end", 32'(DivAck), 32'd0);
    check("err_pulse_end", 32'(DivErr), 32'd0);
  endtask

  // Leave RUN one cycle before the next scheduled Tick would land.
  task automatic stop_run(input int last, input int period, input logic [1:0] haltCode);
    while (cyc < last + period - 1) tick_clk(1);
    Mode = haltCode;
    tick_clk(3);
    check("busy_stopped", 32'(Busy), 32'd0);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    int last;
    int lcyc;
    int m;

    vecs[0] = '{1'b0, 25'd0, 1'b0, 1'b0, 50, 4, MODE_HALT};
    vecs[1] = '{1'b1, 25'd0, 1'b0, 1'b1, 50, 2, MODE_ALT};
    vecs[2] = '{1'b1, 25'd3, 1'b1, 1'b0, 3,  5, MODE_HALT};
    vecs[3] = '{1'b1, 25'd0, 1'b0, 1'b1, 3,  3, MODE_ALT};
    vecs[4] = '{1'b1, 25'd7, 1'b1, 1'b0, 7,  3, MODE_HALT};
    vecs[5] = '{1'b1, 25'd2, 1'b1, 1'b0, 2,  4, MODE_HALT};
    vecs[6] = '{1'b1, 25'd1, 1'b1, 1'b0, 1,  6, MODE_ALT};
    vecs[7] = '{1'b1, 25'd0, 1'b0, 1'b1, 1,  3, MODE_HALT};

    Rst     = 1'b0;
    Mode    = MODE_HALT;
    StepBtn = 1'b0;
    DivIn   = '0;
    DivLoad = 1'b0;
    tick_clk(3);
    check("rst_tick",  32'(Tick),      32'd0);
    check("rst_phase", 32'(Phase),     32'd0);
    check("rst_busy",  32'(Busy),      32'd0);
    check("rst_ack",   32'(DivAck),    32'd0);
    check("rst_err",   32'(DivErr),    32'd0);
    check("rst_count", 32'(TickCount), 32'd0);
    Rst = 1'b1;
    tick_clk(1);
    monEn = 1'b1;

    // Table: optional load from HALT, then RUN with a fixed expected period.
    for (int i = 0; i < NVEC; i++) begin
      Mode = MODE_HALT;
      tick_clk(2);
      if (vecs[i].load) do_load(vecs[i].divIn, vecs[i].expAck, vecs[i].expErr);
      n    = cyc;
      Mode = MODE_RUN;
      push_ticks(n + 1 + vecs[i].period, vecs[i].period, vecs[i].nTicks, last);
      tick_clk(1);
      check("busy_run", 32'(Busy), 32'd1);
      stop_run(last, vecs[i].period, vecs[i].haltMode);
      if (i == 0) begin
        check("phase_after4", 32'(Phase),     32'd0);
        check("count_after4", 32'(TickCount), 32'd4);
      end
    end

    // Mid-RUN load: Div 7 -> 3, period restarts from the load edge.
    do_load(25'd7, 1'b1, 1'b0);
    n    = cyc;
    Mode = MODE_RUN;
    push_ticks(n + 8, 7, 1, last);
    while (cyc < n + 9) tick_clk(1);
    lcyc = cyc + 1;
    do_load(25'd3, 1'b1, 1'b0);
    push_ticks(lcyc + 3, 3, 4, last);
    stop_run(last, 3, MODE_HALT);

    // Load on the exact terminal-count edge: that Tick is suppressed.
    n    = cyc;
    Mode = MODE_RUN;
    push_ticks(n + 4, 3, 2, last);
    while (cyc < n + 9) tick_clk(1);
    lcyc = cyc + 1;
    do_load(25'd3, 1'b1, 1'b0);
    push_ticks(lcyc + 3, 3, 2, last);
    stop_run(last, 3, MODE_HALT);

    // STEP: one Tick per press, three cycles after the first high sample.
    Mode = MODE_STEP;
    tick_clk(3);
    check("busy_step", 32'(Busy), 32'd0);
    n       = cyc;
    StepBtn = 1'b1;
    push_ticks(n + 4, 1, 1, last);
    tick_clk(20);
    StepBtn = 1'b0;
    tick_clk(5);
    n       = cyc;
    StepBtn = 1'b1;
    push_ticks(n + 4, 1, 1, last);
    tick_clk(4);
    StepBtn = 1'b0;
    tick_clk(5);
    Mode = MODE_HALT;
    tick_clk(2);
    StepBtn = 1'b1;
    tick_clk(6);
    StepBtn = 1'b0;
    tick_clk(5);
    StepBtn = 1'b1;
    tick_clk(10);
    Mode = MODE_STEP;
    tick_clk(5);
    StepBtn = 1'b0;
    tick_clk(3);
    Mode = MODE_HALT;
    tick_clk(2);
    check("count_after_step", 32'(TickCount), 32'(modelCnt));

    // Reset mid-RUN with Div=7: everything clears, divisor returns to 50.
    do_load(25'd7, 1'b1, 1'b0);
    n    = cyc;
    Mode = MODE_RUN;
    push_ticks(n + 8, 7, 4, last);
    while (cyc < n + 31) tick_clk(1);
    m   = cyc;
    Rst = 1'b0;
    tick_clk(1);
    check("mrst_tick",  32'(Tick),      32'd0);
    check("mrst_phase", 32'(Phase),     32'd0);
    check("mrst_busy",  32'(Busy),      32'd0);
    check("mrst_ack",   32'(DivAck),    32'd0);
    check("mrst_err",   32'(DivErr),    32'd0);
    check("mrst_count", 32'(TickCount), 32'd0);
    modelPhase = 1'b0;
    modelCnt   = 16'd0;
    Rst = 1'b1;
    tick_clk(1);
    check("busy_after_rst", 32'(Busy), 32'd1);
    push_ticks(m + 2 + 50, 50, 2, last);
    stop_run(last, 50, MODE_HALT);

    // Div=1: Tick every cycle, TickCount wraps through 0xFFFF -> 0x0000.
    do_load(25'd1, 1'b1, 1'b0);
    n    = cyc;
    Mode = MODE_RUN;
    push_ticks(n + 2, 1, 65540, last);
    stop_run(last, 1, MODE_HALT);
    check("count_after_wrap", 32'(TickCount), 32'(modelCnt));

    tick_clk(5);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
    $finish;
  end

endmodule
